// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-stage control unit: opcodes, control
// field encodings, stage FSM states and the decoded control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {BR_NONE = 2'b00, BR_COND = 2'b01, BR_JAL = 2'b10, BR_JALR = 2'b11} branch_t;
    typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100} imm_src_t;
    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11} result_src_t;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_CMP = 2'b01, ALU_RFUNCT = 2'b10, ALU_IFUNCT = 2'b11} alu_op_t;

    typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_HAZARD = 2'b10} ctrl_state_t;

    typedef struct packed {
        branch_t     branch;
        imm_src_t    imm_src;
        logic        alu_src_a;
        logic        alu_src;
        result_src_t result_src;
        alu_op_t     alu_op;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        illegal;
        logic        mul_div;
        logic        use_rs1;
        logic        use_rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder producing the control bundle.
// Optional RV32M recognition is enabled by defining RV32M_MULDIV_EN.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RF_AW = 5
) (
    input  logic [6:0]   opcode,
    input  logic [6:0]   funct7,
    input  logic [4:0]   rs1_f,
    input  logic [4:0]   rs2_f,
    input  logic [4:0]   rd_f,
    output ctrl_bundle_t ctrl
);

    ctrl_bundle_t c;
    logic         use_rd;
    logic         known;
    logic         reg_bad;
    logic         f7_bad;

    always_comb begin
        c       = CTRL_NONE;
        use_rd  = 1'b0;
        known   = 1'b1;
        reg_bad = 1'b0;
        f7_bad  = 1'b0;
        case (opcode)
            OP_R: begin
                c.alu_op = ALU_RFUNCT; c.reg_write = 1'b1;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_IMM: begin
                c.alu_op = ALU_IFUNCT; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_LOAD: begin
                c.alu_src = 1'b1; c.result_src = RES_MEM; c.mem_read = 1'b1;
                c.reg_write = 1'b1; c.use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_STORE: begin
                c.imm_src = IMM_S; c.alu_src = 1'b1; c.mem_write = 1'b1;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                c.imm_src = IMM_B; c.alu_op = ALU_CMP; c.branch = BR_COND;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            OP_JAL: begin
                c.imm_src = IMM_J; c.result_src = RES_PC4; c.branch = BR_JAL;
                c.reg_write = 1'b1; use_rd = 1'b1;
            end
            OP_JALR: begin
                c.alu_src = 1'b1; c.result_src = RES_PC4; c.branch = BR_JALR;
                c.reg_write = 1'b1; c.use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_LUI: begin
                c.imm_src = IMM_U; c.result_src = RES_IMM; c.reg_write = 1'b1;
                use_rd = 1'b1;
            end
            OP_AUIPC: begin
                c.imm_src = IMM_U; c.alu_src_a = 1'b1; c.alu_src = 1'b1;
                c.reg_write = 1'b1; use_rd = 1'b1;
            end
            default: known = 1'b0;
        endcase

        // RV32E has only 16 registers; index bit 4 is only meaningful in fields the format uses.
        reg_bad = (RF_AW == 4) && ((c.use_rs1 && rs1_f[4]) || (c.use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]));

`ifdef RV32M_MULDIV_EN
        if (opcode == OP_R && funct7 == F7_MULDIV) c.mul_div = 1'b1;
`else
        f7_bad = (opcode == OP_R) && (funct7 == F7_MULDIV);
`endif

        // Illegal instructions still travel down the pipe, but with every control field neutralised.
        if (!known || reg_bad || f7_bad) begin
            c         = CTRL_NONE;
            c.illegal = 1'b1;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode-stage control slot with valid/ready handshake, load-use
// bubbling and flush. RV32M_MULDIV_EN enables mul_div decoding.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       Branch,
    output logic [2:0]       ImmSrc,
    output logic             ALUSrcA,
    output logic             ALUSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic [RF_AW-1:0] rs1,
    output logic [RF_AW-1:0] rs2,
    output logic [RF_AW-1:0] rd,
    output logic [2:0]       funct3,
    output logic             funct7b5,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal,
    output logic             mul_div,
    output ctrl_state_t      fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and the slot is frozen while out_valid & !out_ready.

    ctrl_state_t      state, state_next;
    ctrl_bundle_t     dec;
    logic [RF_AW-1:0] in_rs1, in_rs2;
    logic             hazard;
    logic             accept;

    ctrl_decode #(.RF_AW(RF_AW)) u_decode (
        .opcode (instr[6:0]),
        .funct7 (instr[31:25]),
        .rs1_f  (instr[19:15]),
        .rs2_f  (instr[24:20]),
        .rd_f   (instr[11:7]),
        .ctrl   (dec)
    );

    assign in_rs1 = instr[15 +: RF_AW];
    assign in_rs2 = instr[20 +: RF_AW];

    // Load in the slot is leaving now; a dependent consumer must wait one cycle.
    assign hazard = (state == ST_FULL) && MemRead && (rd != '0) && out_ready && in_valid &&
                    ((dec.use_rs1 && in_rs1 == rd) || (dec.use_rs2 && in_rs2 == rd));

    assign in_ready  = !flush && (state != ST_FULL || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_HAZARD: state_next = accept ? ST_FULL : ST_EMPTY;
                ST_FULL: begin
                    if (hazard)         state_next = ST_HAZARD;
                    else if (out_ready) state_next = accept ? ST_FULL : ST_EMPTY;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Branch    <= '0;
            ImmSrc    <= '0;
            ALUSrcA   <= 1'b0;
            ALUSrc    <= 1'b0;
            ResultSrc <= '0;
            ALUOp     <= '0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            illegal   <= 1'b0;
            mul_div   <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            funct3    <= '0;
            funct7b5  <= 1'b0;
            pc_out    <= '0;
        end else if (accept) begin
            Branch    <= dec.branch;
            ImmSrc    <= dec.imm_src;
            ALUSrcA   <= dec.alu_src_a;
            ALUSrc    <= dec.alu_src;
            ResultSrc <= dec.result_src;
            ALUOp     <= dec.alu_op;
            RegWrite  <= dec.reg_write;
            MemWrite  <= dec.mem_write;
            MemRead   <= dec.mem_read;
            illegal   <= dec.illegal;
            mul_div   <= dec.mul_div;
            rs1       <= in_rs1;
            rs2       <= in_rs2;
            rd        <= instr[7 +: RF_AW];
            funct3    <= instr[14:12];
            funct7b5  <= instr[30];
            pc_out    <= pc_in;
        end
    end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered decode-stage control unit for the pipelined RV32 core. Sits between the IF/ID and ID/EX pipeline registers. Decodes the opcode of each accepted instruction into the main control bundle and holds it in an output slot with a valid/ready handshake. Adds load-use hazard bubbling, flush, illegal-opcode flagging and AUIPC support.

## Interface
Parameters:
- XLEN, 32, PC width
- RF_AW, 5, register-index width; 4 selects RV32E (index bit 4 set => illegal)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- instr  in  32  instruction word
- pc_in  in  XLEN  PC of instr
- flush  in  1  branch/jump redirect from EX; kills slot and input
- out_valid  out  1  control bundle valid
- out_ready  in  1  ID/EX consumes bundle
- Branch  out  2  00 none, 01 cond, 10 JAL, 11 JALR
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUSrcA  out  1  0 rs1, 1 PC (AUIPC)
- ALUSrc  out  1  0 rs2, 1 immediate
- ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
- ALUOp  out  2  00 add, 01 compare, 10 R funct, 11 I funct
- RegWrite, MemWrite, MemRead  out  1 each
- rs1, rs2, rd  out  RF_AW each
- funct3  out  3; funct7b5  out  1
- pc_out  out  XLEN
- illegal  out  1  unknown opcode or out-of-range register index
- mul_div  out  1  RV32M op (0 when MULDIV_EN undefined)

## Operation
- Decode: R 0110011 (ALUOp 10, RegWrite); OP-IMM 0010011 (ALUOp 11, ALUSrc, RegWrite); LOAD 0000011 (add, ALUSrc, ResultSrc 01, MemRead, RegWrite); STORE 0100011 (ImmSrc 001, ALUSrc, MemWrite); BRANCH 1100011 (ImmSrc 010, ALUOp 01, Branch 01); JAL 1101111 (ImmSrc 011, ResultSrc 10, Branch 10, RegWrite); JALR 1100111 (ALUSrc, ResultSrc 10, Branch 11, RegWrite); LUI 0110111 (ImmSrc 100, ResultSrc 11, RegWrite); AUIPC 0010111 (ImmSrc 100, ALUSrcA, ALUSrc, RegWrite).
- Any other opcode: all enables 0, Branch 00, illegal=1; bundle still delivered (EX raises trap).
- RF_AW=4: rs1/rs2/rd bit 4 set in a used field => illegal=1, enables cleared.
- FSM (package enum): EMPTY (out_valid=0), FULL (out_valid=1), HAZARD (out_valid=0, one-cycle bubble).
- in_ready = !flush & (state!=FULL | out_ready) & !hazard.
- hazard: state FULL & MemRead & rd!=0 & out_ready & in_valid & incoming instruction uses rs1 or rs2 equal to slot rd. Slot drains, instruction not accepted, next state HAZARD.
- HAZARD -> FULL on accept, else EMPTY. FULL -> FULL on accept+drain, EMPTY on drain without accept, holds otherwise. EMPTY -> FULL on accept.
- Slot contents held stable while out_valid & !out_ready.
- flush: highest priority; next state EMPTY, input dropped, in_ready=0.

## Timing
- Latency 1 cycle: accepted at edge N, out_valid high after edge N.
- Throughput 1/cycle without hazards; load-use costs exactly one bubble.
- Reset (async, any time, including mid-hazard): state EMPTY, out_valid 0, all control outputs 0, rs1/rs2/rd/funct3/funct7b5/pc_out 0, illegal 0, mul_div 0.
- flush with out_ready=1 in same cycle: slot counts as consumed and is not re-presented.
- Outputs are registers; only in_ready is combinational.

## Configuration
- RV32M_MULDIV_EN defined: opcode 0110011 with funct7=0000001 sets mul_div=1 (other fields as R-type).
- Undefined: mul_div tied 0; funct7=0000001 R-type flagged illegal.

## Structure
- Package ctrl_pkg: opcode constants, Branch/ImmSrc/ResultSrc/ALUOp encodings, FSM state enum, ctrl_bundle_t struct.
- One sub-module: ctrl_decode (pure combinational opcode -> ctrl_bundle_t); stage module owns FSM, hazard and slot register.

## Test plan
- Reset mid-stream with out_valid=1 -> next cycle out_valid=0, all outputs 0, state EMPTY.
- lw x5,0(x1) then add x6,x5,x2 back-to-back, out_ready=1 -> lw bundle, one cycle out_valid=0, then add bundle; in_ready=0 for exactly one cycle.
- lw x0 then add x6,x0,x2 -> no bubble.
- out_ready=0 for 3 cycles with FULL slot -> bundle stable, in_ready=0; release -> next instruction next cycle.
- flush while FULL and in_valid=1 -> out_valid=0 next cycle, input not accepted.
- Opcode 0010111 -> ALUSrcA=1, ImmSrc=100; opcode 1111111 -> illegal=1, RegWrite=0; mul x3,x1,x2 -> mul_div=1 with RV32M_MULDIV_EN, illegal=1 without.
